// File: rtl/dpram_w2_writer_pkg.sv
// Shared types and defaults for the double-width RAM writer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dpram_w2_writer_pkg;

    localparam int DEF_ADDRESS_WIDTH = 10;
    localparam int DEF_DATA_WIDTH    = 8;

    // Encoding is fixed so a debug overlay or bench can decode a probed state value.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } wr_state_t;

endpackage

// File: rtl/dpram_w2_writer.sv
// Splits double-width stream/fill words into two byte writes (high half at ptr, low at ptr+1).
// Latency: stream accept at edge T -> HI byte written in cycle T+1, LO byte in cycle T+2.
// Backpressure: in_ready only in WAIT, or in LO when more stream words remain; fill never asks.
module dpram_w2_writer
    import dpram_w2_writer_pkg::*;
#(
    parameter int address_width = DEF_ADDRESS_WIDTH,
    parameter int data_width    = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_start,
    input  logic                      cmd_fill,
    input  logic [address_width-1:0]  cmd_address,
    input  logic [address_width-1:0]  cmd_count,
    input  logic                      cmd_abort,
    input  logic [2*data_width-1:0]   fill_value,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*data_width-1:0]   in_data,
    output logic                      busy,
    output logic                      done,
    output logic                      wren,
    output logic [address_width-1:0]  address,
    output logic [data_width-1:0]     data
);

    localparam int AW = address_width;
    localparam int DW = data_width;

    wr_state_t         state_q;
    logic [AW-1:0]     ptr_q;
    logic [AW-1:0]     rem_q;
    logic [2*DW-1:0]   word_q;
    logic              fill_q;

    logic              accept;
    logic              last_word;
    logic [AW-1:0]     ptr_plus1;
    logic [AW-1:0]     ptr_plus2;

    // Ready is a pure state/remaining decode so the source never sees a combinational path back.
    assign in_ready  = (state_q == ST_WAIT) ||
                       ((state_q == ST_LO) && !fill_q && (rem_q > AW'(1)));
    assign accept    = in_valid && in_ready;
    assign last_word = (rem_q == AW'(1));
    assign ptr_plus1 = ptr_q + AW'(1);
    assign ptr_plus2 = ptr_q + AW'(2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            fill_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wren    <= 1'b0;
            address <= '0;
            data    <= '0;
        end else begin
            done <= 1'b0;
            if ((state_q != ST_IDLE) && cmd_abort) begin
                // Abort wins over any accept in the same cycle; a written HI byte stays written.
                state_q <= ST_IDLE;
                busy    <= 1'b0;
                wren    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        wren <= 1'b0;
                        busy <= 1'b0;
                        if (cmd_start && !cmd_abort) begin
                            ptr_q  <= cmd_address;
                            rem_q  <= cmd_count;
                            fill_q <= cmd_fill;
                            word_q <= fill_value;
                            if (cmd_count == '0) begin
                                done <= 1'b1;
                            end else if (cmd_fill) begin
                                state_q <= ST_HI;
                                busy    <= 1'b1;
                                wren    <= 1'b1;
                                address <= cmd_address;
                                data    <= fill_value[2*DW-1:DW];
                            end else begin
                                state_q <= ST_WAIT;
                                busy    <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        wren <= 1'b0;
                        if (accept) begin
                            word_q  <= in_data;
                            state_q <= ST_HI;
                            wren    <= 1'b1;
                            address <= ptr_q;
                            data    <= in_data[2*DW-1:DW];
                        end
                    end
                    ST_HI: begin
                        state_q <= ST_LO;
                        wren    <= 1'b1;
                        address <= ptr_plus1;
                        data    <= word_q[DW-1:0];
                    end
                    ST_LO: begin
                        ptr_q <= ptr_plus2;
                        rem_q <= rem_q - AW'(1);
                        if (last_word) begin
                            state_q <= ST_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            wren    <= 1'b0;
                        end else if (fill_q) begin
                            state_q <= ST_HI;
                            wren    <= 1'b1;
                            address <= ptr_plus2;
                            data    <= word_q[2*DW-1:DW];
                        end else if (accept) begin
                            // Back-to-back stream word: no WAIT bubble, keeps one byte per clock.
                            word_q  <= in_data;
                            state_q <= ST_HI;
                            wren    <= 1'b1;
                            address <= ptr_plus2;
                            data    <= in_data[2*DW-1:DW];
                        end else begin
                            state_q <= ST_WAIT;
                            wren    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                        wren    <= 1'b0;
                    end
                endcase
            end
        end
    end

    a_wren_only_when_busy: assert property (@(posedge clk) disable iff (!reset_n)
        wren |-> busy);

    a_done_not_busy: assert property (@(posedge clk) disable iff (!reset_n)
        done |-> !busy);

    a_fill_never_ready: assert property (@(posedge clk) disable iff (!reset_n)
        (fill_q && (state_q != ST_IDLE)) |-> !in_ready);

endmodule
